spi_master_cfg: RTL

- Runtime-configurable SPI master; successor to the fixed-length 4-byte SPI master.
- Adds per-transaction bit length, MSB/LSB-first order, runtime clock divider and all four CPOL/CPHA modes with correct sample/shift edges.
- Adds asynchronous active-low reset and a busy/valid handshake.
- Sits between the control logic (register interface) and off-chip SPI peripherals. Drives up to N active-low slave selects.

---
 rtl/spi_master_cfg.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/spi_master_cfg.sv
// spi_master_cfg: runtime-configurable SPI master with per-transfer length, bit order, divider and CPOL/CPHA
// Ports: CLK_IN/RST_N clock and async active-low reset; trigger/din/len/clk_div/target/CPOL/CPHA/LSB_FIRST
// transaction request and configuration (latched on acceptance); busy/valid/dout handshake and result;
// MISO/MOSI/SPI_CLK/SPI_SS serial interface with N active-low selects.
module spi_master_cfg #(
    parameter int N        = 1,
    parameter int C        = 32,
    parameter int LEN_W    = 6,
    parameter int DIV_W    = 16,
    parameter int SS_SPACE = 1
) (
    input  logic             CLK_IN,
    input  logic             RST_N,
    input  logic             trigger,
    input  logic [C-1:0]     din,
    input  logic [LEN_W-1:0] len,
    input  logic [DIV_W-1:0] clk_div,
    input  logic [N-1:0]     target,
    input  logic             CPOL,
    input  logic             CPHA,
    input  logic             LSB_FIRST,
    output logic             busy,
    output logic             valid,
    output logic [C-1:0]     dout,
    input  logic             MISO,
    output logic             MOSI,
    output logic             SPI_CLK,
    output logic [N-1:0]     SPI_SS
);
    localparam int HW = $clog2(2 * C + SS_SPACE) + 1;

    typedef enum logic [2:0] {IDLE, START, LEAD, XFER, TRAIL, DONE} state_t;

    state_t           state;
    logic [C-1:0]     tx, rx, ld_tx, ld_sh, tx_nx, rx_nx, rx_out;
    logic [LEN_W-1:0] len_q, eff_len;
    logic [DIV_W-1:0] div_q, cnt;
    logic [N-1:0]     tgt_q;
    logic [HW-1:0]    h, x_last;
    logic             cpol_q, cpha_q, lsb_q, sclk, tick, last, ld_bit, tx_bit;

    assign eff_len = (len == '0 || len > LEN_W'(C)) ? LEN_W'(C) : len;
    // MSB-first words are pre-aligned to the top so the outgoing bit is always tx[C-1]
    assign ld_tx   = LSB_FIRST ? din : din << (LEN_W'(C) - eff_len);
    assign ld_bit  = LSB_FIRST ? ld_tx[0] : ld_tx[C-1];
    assign ld_sh   = LSB_FIRST ? ld_tx >> 1 : ld_tx << 1;
    assign tx_bit  = lsb_q ? tx[0] : tx[C-1];
    assign tx_nx   = lsb_q ? tx >> 1 : tx << 1;
    assign rx_nx   = lsb_q ? {MISO, rx[C-1:1]} : {rx[C-2:0], MISO};
    // LSB-first reception fills from the top; realign to bit 0 on completion
    assign rx_out  = lsb_q ? rx >> (LEN_W'(C) - len_q) : rx;
    assign tick    = cnt == div_q;
    assign last    = h == ((state == XFER) ? x_last : HW'(SS_SPACE - 1));
    assign SPI_CLK = (state == IDLE) ? CPOL : sclk;

    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            state  <= IDLE;
            busy   <= 1'b0;
            valid  <= 1'b0;
            dout   <= '0;
            MOSI   <= 1'b0;
            SPI_SS <= '1;
            tx     <= '0;
            rx     <= '0;
            cnt    <= '0;
            h      <= '0;
            x_last <= '0;
            len_q  <= '0;
            div_q  <= '0;
            tgt_q  <= '0;
            cpol_q <= 1'b0;
            cpha_q <= 1'b0;
            lsb_q  <= 1'b0;
            sclk   <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (trigger) begin
                        len_q  <= eff_len;
                        x_last <= HW'({eff_len, 1'b0}) - 1'b1;
                        div_q  <= clk_div;
                        tgt_q  <= target;
                        cpol_q <= CPOL;
                        cpha_q <= CPHA;
                        lsb_q  <= LSB_FIRST;
                        // CPHA=0 presents the first bit before any edge; CPHA=1 waits for the first leading edge
                        tx     <= CPHA ? ld_tx : ld_sh;
                        MOSI   <= CPHA ? MOSI : ld_bit;
                        rx     <= '0;
                        cnt    <= '0;
                        h      <= '0;
                        sclk   <= CPOL;
                        busy   <= 1'b1;
                        // back-to-back skips START so SS stays high for exactly the DONE cycle
                        SPI_SS <= (state == DONE) ? ~target : '1;
                        state  <= (state == DONE) ? LEAD : START;
                    end else begin
                        state <= IDLE;
                    end
                end
                START: begin
                    SPI_SS <= ~tgt_q;
                    state  <= LEAD;
                end
                LEAD: begin
                    cnt <= tick ? '0 : cnt + 1'b1;
                    if (tick) begin
                        h <= last ? '0 : h + 1'b1;
                        if (last) state <= XFER;
                    end
                end
                XFER: begin
                    cnt <= tick ? '0 : cnt + 1'b1;
                    if (tick) begin
                        h    <= last ? '0 : h + 1'b1;
                        sclk <= last ? cpol_q : ~sclk;
                        if (last) state <= TRAIL;
                        // even h opens a leading edge; the sampling edge is leading for CPHA=0, trailing for CPHA=1
                        if (last ? cpha_q : (~h[0] ^ cpha_q)) begin
                            rx <= rx_nx;
                        end else if (!last) begin
                            MOSI <= tx_bit;
                            tx   <= tx_nx;
                        end
                    end
                end
                TRAIL: begin
                    cnt <= tick ? '0 : cnt + 1'b1;
                    if (tick) begin
                        h <= last ? '0 : h + 1'b1;
                        if (last) begin
                            state  <= DONE;
                            SPI_SS <= '1;
                            busy   <= 1'b0;
                            valid  <= 1'b1;
                            dout   <= rx_out;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
